// File: rtl/fetch_controller_if.sv
// Fetch-to-memory/decode/execute signal bundle for the picoMIPS fetch stage.
// The master modport is the fetch controller's view; slave is the environment's.
interface fetch_controller_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               halted;

  modport master (
    input  start, imem_instr, instr_ready, branch_valid, branch_target,
    output imem_addr, instr_out, pc_out, instr_valid, halted
  );

  modport slave (
    output start, imem_instr, instr_ready, branch_valid, branch_target,
    input  imem_addr, instr_out, pc_out, instr_valid, halted
  );
endinterface

// File: rtl/fetch_controller.sv
// picoMIPS fetch stage: owns the PC, registers the instruction into a one-entry
// valid/ready output stage, applies branch redirects and stops on a halt opcode.
module fetch_controller #(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic load;
  logic accept;

  assign accept = valid_q && bus.instr_ready;
  // Branch suppresses the load so the redirected PC is fetched on the next edge.
  assign load   = (state_q == RUN) && (!valid_q || bus.instr_ready) && !bus.branch_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end

      RUN: begin
        if (bus.branch_valid) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
        end else if (load) begin
          instr_d  = bus.imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
          if (bus.imem_instr == HALT_INSTR) state_d = HALT_PEND;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end

      HALT_PEND: begin
        if (bus.branch_valid) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (accept) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALTED;
        end
      end

      HALTED: begin
        if (bus.start) begin
          pc_d     = RESET_PC;
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: fetch, backpressure, branch, wrap, halt, reset.
module tb_fetch_controller;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  logic [15:0] mem [256];

  fetch_controller_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_controller #(
    .ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_INSTR(16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.imem_instr = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    rst = 1'b1;
    bus.start = 1'b0; bus.instr_ready = 1'b1;
    bus.branch_valid = 1'b0; bus.branch_target = 8'h00;
    #2;
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("rst_instr",  32'(bus.instr_out),   32'h0);
    chk("rst_pcout",  32'(bus.pc_out),      32'h0);
    chk("rst_halted", 32'(bus.halted),      32'h0);
    chk("rst_addr",   32'(bus.imem_addr),   32'h0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_nofetch", 32'(bus.instr_valid), 32'h0);

    // 1. basic fetch
    bus.start = 1'b1;
    step();                               // e0: enter RUN
    bus.start = 1'b0;
    chk("e0_valid", 32'(bus.instr_valid), 32'h0);
    step();
    chk("e1_instr", 32'(bus.instr_out), 32'h1111);
    chk("e1_pc",    32'(bus.pc_out),    32'h0);
    chk("e1_valid", 32'(bus.instr_valid), 32'h1);
    step();
    chk("e2_instr", 32'(bus.instr_out), 32'h2222);
    chk("e2_pc",    32'(bus.pc_out),    32'h1);
    step();
    chk("e3_instr", 32'(bus.instr_out), 32'h3333);
    chk("e3_pc",    32'(bus.pc_out),    32'h2);

    // 2. backpressure
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", 32'(bus.instr_out), 32'h3333);
      chk("bp_pc",    32'(bus.pc_out),    32'h2);
      chk("bp_addr",  32'(bus.imem_addr), 32'h3);
    end
    bus.instr_ready = 1'b1;
    step();
    chk("bp_rel_pc",    32'(bus.pc_out),    32'h3);
    chk("bp_rel_instr", 32'(bus.instr_out), 32'h4444);

    // 3. branch flush while stalled
    step(); step();
    chk("pre_br_pc", 32'(bus.pc_out), 32'h5);
    bus.instr_ready = 1'b0;
    bus.branch_valid = 1'b1; bus.branch_target = 8'h40;
    step();
    bus.branch_valid = 1'b0;
    chk("br_flush", 32'(bus.instr_valid), 32'h0);
    chk("br_addr",  32'(bus.imem_addr),   32'h40);
    step();
    chk("br_instr", 32'(bus.instr_out),   32'hA540);
    chk("br_pc",    32'(bus.pc_out),      32'h40);
    chk("br_valid", 32'(bus.instr_valid), 32'h1);
    bus.instr_ready = 1'b1;

    // 4. wrap-around
    bus.branch_valid = 1'b1; bus.branch_target = 8'hFE;
    step();
    bus.branch_valid = 1'b0;
    chk("wr_addr_fe", 32'(bus.imem_addr), 32'hFE);
    step();
    chk("wr_pc_fe",   32'(bus.pc_out),    32'hFE);
    chk("wr_addr_ff", 32'(bus.imem_addr), 32'hFF);
    step();
    chk("wr_pc_ff",   32'(bus.pc_out),    32'hFF);
    chk("wr_addr_00", 32'(bus.imem_addr), 32'h00);
    step();
    chk("wr_pc_00",   32'(bus.pc_out),    32'h00);
    step();
    chk("wr_pc_01",   32'(bus.pc_out),    32'h01);

    // 5. halt and restart
    mem[3] = 16'hFFFF;
    step();
    chk("h_pc2", 32'(bus.pc_out), 32'h2);
    step();
    chk("h_pc3",   32'(bus.pc_out),    32'h3);
    chk("h_instr", 32'(bus.instr_out), 32'hFFFF);
    bus.instr_ready = 1'b0;
    step(); step();
    chk("hp_addr",   32'(bus.imem_addr),   32'h4);
    chk("hp_pc",     32'(bus.pc_out),      32'h3);
    chk("hp_valid",  32'(bus.instr_valid), 32'h1);
    chk("hp_halted", 32'(bus.halted),      32'h0);
    bus.instr_ready = 1'b1;
    step();
    chk("hp_noload", 32'(bus.imem_addr),   32'h4);
    chk("hd_halted", 32'(bus.halted),      32'h1);
    chk("hd_valid",  32'(bus.instr_valid), 32'h0);
    bus.branch_valid = 1'b1; bus.branch_target = 8'h20;
    step();
    bus.branch_valid = 1'b0;
    chk("hd_br_ign",  32'(bus.imem_addr), 32'h4);
    chk("hd_br_halt", 32'(bus.halted),    32'h1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rs_halted", 32'(bus.halted),    32'h0);
    chk("rs_addr",   32'(bus.imem_addr), 32'h0);
    step();
    chk("rs_pc",    32'(bus.pc_out),      32'h0);
    chk("rs_instr", 32'(bus.instr_out),   32'h1111);
    chk("rs_valid", 32'(bus.instr_valid), 32'h1);

    // 6. async reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.instr_valid), 32'h0);
    chk("ar_instr", 32'(bus.instr_out),   32'h0);
    chk("ar_addr",  32'(bus.imem_addr),   32'h0);
    chk("ar_pcout", 32'(bus.pc_out),      32'h0);
    step();
    rst = 1'b0;
    step(); step();
    chk("ar_idle_valid", 32'(bus.instr_valid), 32'h0);
    chk("ar_idle_addr",  32'(bus.imem_addr),   32'h0);

    // start beats branch in IDLE
    bus.start = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 8'h80;
    step();
    bus.start = 1'b0; bus.branch_valid = 1'b0;
    chk("sw_addr", 32'(bus.imem_addr), 32'h0);
    step();
    chk("sw_pc",    32'(bus.pc_out),    32'h0);
    chk("sw_instr", 32'(bus.instr_out), 32'h1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 256 x 16-bit instruction memory for the picoMIPS core.
- Owns the program counter and drives the memory address.
- Registers the returned instruction into a one-entry output stage with a valid/ready handshake toward decode.
- Handles branch redirects from execute and stops fetching on a halt instruction.

Parameters:
ADDR_W, 8, program counter / instruction memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value after reset and on restart
HALT_INSTR, 16'hFFFF, encoding that stops fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin fetching (sampled in IDLE or HALTED only)
imem_addr  out  ADDR_W  address to instruction memory; always equals pc
imem_instr  in  INSTR_W  combinational read data for imem_addr, valid in the same cycle
instr_out  out  INSTR_W  registered instruction to decode
pc_out  out  ADDR_W  address that instr_out was fetched from
instr_valid  out  1  instr_out holds a live instruction
instr_ready  in  1  decode accepts instr_out this cycle
branch_valid  in  1  redirect request from execute
branch_target  in  ADDR_W  redirect address
halted  out  1  halt instruction has been consumed; fetch stopped

Behaviour:
- Reset (async, immediate, no clock needed):
  - state = IDLE, pc = RESET_PC.
  - instr_out = 0, pc_out = 0, instr_valid = 0, halted = 0.
- States (2-bit encoding): IDLE, RUN, HALT_PEND, HALTED.
- IDLE:
  - No loads.
  - start = 1 -> RUN. pc is unchanged.
  - branch_valid is ignored.
- RUN, load condition: (!instr_valid || instr_ready) && !branch_valid.
  - On load: instr_out <= imem_instr, pc_out <= pc, instr_valid <= 1, pc <= pc + 1.
  - pc arithmetic is modulo 2^ADDR_W, so 0xFF wraps to 0x00.
  - Throughput is one instruction per cycle while instr_ready = 1.
- RUN, acceptance:
  - instr_valid && instr_ready with no load that cycle -> instr_valid <= 0.
- RUN, backpressure:
  - instr_valid && !instr_ready -> instr_out, pc_out and pc are all held.
- Branch (RUN or HALT_PEND), branch_valid = 1 at an edge:
  - pc <= branch_target.
  - instr_valid <= 0; any pending instruction is flushed, whether or not it was accepted that cycle.
  - state <= RUN.
  - No load that edge.
  - The target instruction appears with instr_valid = 1 at the following edge.
  - Branch beats both load and halt.
- Halt detection:
  - A load whose imem_instr == HALT_INSTR is presented normally (valid, pc_out), and the state goes to HALT_PEND.
  - pc still increments on that load.
- HALT_PEND:
  - No further loads.
  - When the halt instruction is accepted -> HALTED, instr_valid <= 0, halted <= 1.
- HALTED:
  - Everything is frozen; branch_valid is ignored.
  - start = 1 -> pc <= RESET_PC, halted <= 0, state <= RUN.
  - The first instruction appears at the next edge.
- Simultaneous start and branch_valid in IDLE/HALTED: start wins, branch is ignored.
- start in RUN or HALT_PEND is ignored.
- Reset mid-operation: everything returns to reset values immediately; the in-flight instruction is lost.
- imem_addr is combinational from pc in every state.

Test Plan:
1. Basic fetch:
   - Stimulus: mem[0..3] = 1111, 2222, 3333, 4444; reset; start pulsed 1 cycle; instr_ready = 1.
   - Response: RUN entered at edge e0; instr_out = 1111 / pc_out = 0 at e1, then 2222 / 1 at e2, 3333 / 2 at e3.
2. Backpressure:
   - Stimulus: instr_ready = 0 for 3 cycles while pc_out = 2 is valid.
   - Response: instr_out = 3333, pc_out = 2 and imem_addr = 3 stay stable; after ready returns, the next edge gives pc_out = 3, instr_out = 4444.
3. Branch flush:
   - Stimulus: pc_out = 5 valid, instr_ready = 0, branch_valid = 1 with target 0x40.
   - Response: next cycle instr_valid = 0 and imem_addr = 0x40; following edge instr_out = mem[0x40], pc_out = 0x40.
4. Wrap-around:
   - Stimulus: branch to 0xFE, then instr_ready = 1.
   - Response: pc_out sequence 0xFE, 0xFF, 0x00, 0x01; imem_addr wraps 0xFF -> 0x00.
5. Halt and restart:
   - Stimulus: mem[3] = FFFF, instr_ready = 0 at pc_out = 3.
   - Response: imem_addr held at 4 and no loads occur. Then raise ready: halted = 1, instr_valid = 0. Pulse start: halted = 0 and pc_out = 0 at the next edge.
6. Async reset:
   - Stimulus: assert rst mid-RUN with instr_valid = 1, between clock edges.
   - Response: instr_valid = 0, instr_out = 0, imem_addr = RESET_PC immediately; after release, no fetch until start.
